// File: rtl/flow_control_unit_if.sv
// Bundle between fetch_unit/ALU and the flow-control unit: decode inputs going in,
// PC-steering controls and return-stack status coming out.
interface flow_control_unit_if #(
    parameter int STACK_DEPTH = 4
);
    localparam int SPW = $clog2(STACK_DEPTH + 1);

    logic           stall;
    logic [9:0]     instr;
    logic [9:0]     pc;
    logic           zero_flag;
    logic [1:0]     fetch_control;
    logic [7:0]     jump_addr;
    logic [9:0]     ra_addr;
    logic [SPW-1:0] sp;
    logic           stack_overflow;
    logic           stack_underflow;

    modport master (
        output stall, instr, pc, zero_flag,
        input  fetch_control, jump_addr, ra_addr, sp, stack_overflow, stack_underflow
    );

    modport slave (
        input  stall, instr, pc, zero_flag,
        output fetch_control, jump_addr, ra_addr, sp, stack_overflow, stack_underflow
    );
endinterface

// File: rtl/flow_control_unit.sv
// Decodes JMP/JZ/CALL/RET words and steers fetch_unit's PC with zero-cycle latency,
// keeping the return addresses for CALL/RET in a small LIFO.
module flow_control_unit #(
    parameter int         STACK_DEPTH = 4,
    parameter logic [3:0] FLOW_PREFIX = 4'b1111
) (
    input logic                 clk,
    input logic                 reset,
    flow_control_unit_if.slave  bus
);
    localparam int SPW = $clog2(STACK_DEPTH + 1);
    localparam int IW  = $clog2(STACK_DEPTH);

    typedef enum logic {DECODE, TARGET} state_t;
    typedef enum logic [1:0] {OP_JMP, OP_JZ, OP_CALL, OP_RET} op_t;

    state_t         state_q, state_d;
    op_t            opLatch_q, opLatch_d;
    logic           zeroLatch_q, zeroLatch_d;
    logic [SPW-1:0] sp_q, sp_d;
    logic           overflow_q, overflow_d;
    logic           underflow_q, underflow_d;
    logic [9:0]     stack_q [STACK_DEPTH];

    logic           doPush;
    logic           isFlow;
    op_t            opcode;
    logic [IW-1:0]  topIdx;
    logic [1:0]     fetchCtl;

    always_comb begin
        isFlow      = (bus.instr[9:6] == FLOW_PREFIX);
        opcode      = op_t'(bus.instr[5:4]);
        topIdx      = IW'(sp_q - SPW'(1));
        state_d     = state_q;
        opLatch_d   = opLatch_q;
        zeroLatch_d = zeroLatch_q;
        sp_d        = sp_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        doPush      = 1'b0;
        fetchCtl    = 2'b00;

        case (state_q)
            DECODE: begin
                if (isFlow) begin
                    if (opcode == OP_RET) begin
                        if (sp_q != '0) begin
                            fetchCtl = 2'b10;
                            sp_d     = sp_q - SPW'(1);
                        end else begin
                            underflow_d = 1'b1;
                        end
                    end else begin
                        opLatch_d   = opcode;
                        zeroLatch_d = (opcode == OP_JZ) ? bus.zero_flag : 1'b0;
                        state_d     = TARGET;
                    end
                end
            end
            TARGET: begin
                state_d = DECODE;
                case (opLatch_q)
                    OP_JMP: fetchCtl = 2'b01;
                    OP_JZ:  fetchCtl = zeroLatch_q ? 2'b01 : 2'b00;
                    OP_CALL: begin
                        fetchCtl = 2'b01;
                        if (sp_q < SPW'(STACK_DEPTH)) begin
                            doPush = 1'b1;
                            sp_d   = sp_q + SPW'(1);
                        end else begin
                            overflow_d = 1'b1;
                        end
                    end
                    default: fetchCtl = 2'b00;
                endcase
            end
            default: state_d = DECODE;
        endcase

        if (bus.stall) begin
            fetchCtl = 2'b11;
        end
    end

    // Reset masks the steering outputs even though they are combinational.
    assign bus.fetch_control   = reset ? 2'b00 : fetchCtl;
    assign bus.jump_addr       = (reset || state_q != TARGET) ? 8'h00 : bus.instr[7:0];
    assign bus.ra_addr         = (reset || sp_q == '0) ? 10'h000 : stack_q[topIdx];
    assign bus.sp              = sp_q;
    assign bus.stack_overflow  = overflow_q;
    assign bus.stack_underflow = underflow_q;

    // Stall freezes every register, including a pending push.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= DECODE;
            opLatch_q   <= OP_JMP;
            zeroLatch_q <= 1'b0;
            sp_q        <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else if (!bus.stall) begin
            state_q     <= state_d;
            opLatch_q   <= opLatch_d;
            zeroLatch_q <= zeroLatch_d;
            sp_q        <= sp_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            if (doPush) begin
                stack_q[sp_q[IW-1:0]] <= bus.pc + 10'd1;
            end
        end
    end
endmodule

// File: tb/tb_flow_control_unit.sv
// Directed bench for flow_control_unit: each feature task drives words and checks
// the combinational steering outputs against hand-computed values.
module tb_flow_control_unit;
    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;

    flow_control_unit_if #(.STACK_DEPTH(4)) bus ();

    flow_control_unit #(.STACK_DEPTH(4), .FLOW_PREFIX(4'b1111)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic [9:0] w, input logic [9:0] p,
                                 input logic z, input logic s);
        bus.instr     = w;
        bus.pc        = p;
        bus.zero_flag = z;
        bus.stall     = s;
        #2;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        applyStimulus(10'h012, 10'h000, 1'b0, 1'b0);
        tick();
        tick();
        vectors++; if (bus.fetch_control !== 2'b00) begin miscompares++; $display("[TB] FAIL rst_fc got %b exp 00", bus.fetch_control); end
        vectors++; if (bus.ra_addr !== 10'h000) begin miscompares++; $display("[TB] FAIL rst_ra got %h exp 000", bus.ra_addr); end
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            applyStimulus(10'h012, 10'(i), 1'b0, 1'b0);
            vectors++; if (bus.fetch_control !== 2'b00) begin miscompares++; $display("[TB] FAIL nonflow_fc got %b exp 00", bus.fetch_control); end
            vectors++; if (bus.sp !== 3'd0) begin miscompares++; $display("[TB] FAIL rst_sp got %0d exp 0", bus.sp); end
            vectors++; if (bus.jump_addr !== 8'h00) begin miscompares++; $display("[TB] FAIL rst_jump got %h exp 00", bus.jump_addr); end
            vectors++; if ({bus.stack_overflow, bus.stack_underflow} !== 2'b00) begin miscompares++; $display("[TB] FAIL rst_flags got %b exp 00", {bus.stack_overflow, bus.stack_underflow}); end
            tick();
        end
    endtask

    task automatic test_jmp();
        applyStimulus(10'h3C0, 10'h010, 1'b0, 1'b0);
        vectors++; if (bus.fetch_control !== 2'b00) begin miscompares++; $display("[TB] FAIL jmp_op_fc got %b exp 00", bus.fetch_control); end
        tick();
        applyStimulus(10'h0A5, 10'h011, 1'b0, 1'b0);
        vectors++; if (bus.fetch_control !== 2'b01) begin miscompares++; $display("[TB] FAIL jmp_tgt_fc got %b exp 01", bus.fetch_control); end
        vectors++; if (bus.jump_addr !== 8'hA5) begin miscompares++; $display("[TB] FAIL jmp_addr got %h exp A5", bus.jump_addr); end
        tick();
        applyStimulus(10'h012, 10'h0A5, 1'b0, 1'b0);
        vectors++; if (bus.fetch_control !== 2'b00) begin miscompares++; $display("[TB] FAIL jmp_back_fc got %b exp 00", bus.fetch_control); end
        vectors++; if (bus.jump_addr !== 8'h00) begin miscompares++; $display("[TB] FAIL jmp_back_addr got %h exp 00", bus.jump_addr); end
        tick();
    endtask

    task automatic test_jz();
        // Zero flag flips on the target word to show only the opcode-cycle value counts.
        applyStimulus(10'h3D0, 10'h020, 1'b0, 1'b0);
        tick();
        applyStimulus(10'h040, 10'h021, 1'b1, 1'b0);
        vectors++; if (bus.fetch_control !== 2'b00) begin miscompares++; $display("[TB] FAIL jz_nt_fc got %b exp 00", bus.fetch_control); end
        tick();
        applyStimulus(10'h3D0, 10'h022, 1'b1, 1'b0);
        tick();
        applyStimulus(10'h040, 10'h023, 1'b0, 1'b0);
        vectors++; if (bus.fetch_control !== 2'b01) begin miscompares++; $display("[TB] FAIL jz_t_fc got %b exp 01", bus.fetch_control); end
        vectors++; if (bus.jump_addr !== 8'h40) begin miscompares++; $display("[TB] FAIL jz_t_addr got %h exp 40", bus.jump_addr); end
        tick();
    endtask

    task automatic test_call_ret();
        applyStimulus(10'h3E0, 10'h100, 1'b0, 1'b0);
        vectors++; if (bus.fetch_control !== 2'b00) begin miscompares++; $display("[TB] FAIL call_op_fc got %b exp 00", bus.fetch_control); end
        tick();
        applyStimulus(10'h080, 10'h101, 1'b0, 1'b0);
        vectors++; if (bus.fetch_control !== 2'b01) begin miscompares++; $display("[TB] FAIL call_tgt_fc got %b exp 01", bus.fetch_control); end
        vectors++; if (bus.jump_addr !== 8'h80) begin miscompares++; $display("[TB] FAIL call_addr got %h exp 80", bus.jump_addr); end
        tick();
        applyStimulus(10'h3F0, 10'h080, 1'b0, 1'b0);
        vectors++; if (bus.sp !== 3'd1) begin miscompares++; $display("[TB] FAIL call_sp got %0d exp 1", bus.sp); end
        vectors++; if (bus.fetch_control !== 2'b10) begin miscompares++; $display("[TB] FAIL ret_fc got %b exp 10", bus.fetch_control); end
        vectors++; if (bus.ra_addr !== 10'h102) begin miscompares++; $display("[TB] FAIL ret_ra got %h exp 102", bus.ra_addr); end
        tick();
        applyStimulus(10'h012, 10'h102, 1'b0, 1'b0);
        vectors++; if (bus.sp !== 3'd0) begin miscompares++; $display("[TB] FAIL ret_sp got %0d exp 0", bus.sp); end
        vectors++; if (bus.ra_addr !== 10'h000) begin miscompares++; $display("[TB] FAIL ret_ra_empty got %h exp 000", bus.ra_addr); end
        tick();
    endtask

    task automatic test_stack_bounds();
        logic [9:0] base;
        logic [2:0] expSp;
        for (int k = 0; k < 5; k++) begin
            base = 10'h200 + 10'(4 * k);
            applyStimulus(10'h3E0, base, 1'b0, 1'b0);
            vectors++; if (bus.stack_overflow !== 1'b0) begin miscompares++; $display("[TB] FAIL ovf_early[%0d] got %b exp 0", k, bus.stack_overflow); end
            tick();
            applyStimulus(10'h020, base + 10'd1, 1'b0, 1'b0);
            vectors++; if (bus.fetch_control !== 2'b01) begin miscompares++; $display("[TB] FAIL nest_fc[%0d] got %b exp 01", k, bus.fetch_control); end
            tick();
            expSp = (k < 4) ? 3'(k + 1) : 3'd4;
            applyStimulus(10'h012, 10'h020, 1'b0, 1'b0);
            vectors++; if (bus.sp !== expSp) begin miscompares++; $display("[TB] FAIL nest_sp[%0d] got %0d exp %0d", k, bus.sp, expSp); end
        end
        vectors++; if (bus.stack_overflow !== 1'b1) begin miscompares++; $display("[TB] FAIL ovf got %b exp 1", bus.stack_overflow); end
        for (int k = 0; k < 5; k++) begin
            applyStimulus(10'h3F0, 10'h300, 1'b0, 1'b0);
            if (k < 4) begin
                base = 10'h202 + 10'(4 * (3 - k));
                vectors++; if (bus.fetch_control !== 2'b10) begin miscompares++; $display("[TB] FAIL pop_fc[%0d] got %b exp 10", k, bus.fetch_control); end
                vectors++; if (bus.ra_addr !== base) begin miscompares++; $display("[TB] FAIL pop_ra[%0d] got %h exp %h", k, bus.ra_addr, base); end
            end else begin
                vectors++; if (bus.fetch_control !== 2'b00) begin miscompares++; $display("[TB] FAIL unf_fc got %b exp 00", bus.fetch_control); end
                vectors++; if (bus.stack_underflow !== 1'b0) begin miscompares++; $display("[TB] FAIL unf_early got %b exp 0", bus.stack_underflow); end
            end
            tick();
        end
        applyStimulus(10'h012, 10'h301, 1'b0, 1'b0);
        vectors++; if (bus.stack_underflow !== 1'b1) begin miscompares++; $display("[TB] FAIL unf got %b exp 1", bus.stack_underflow); end
        vectors++; if (bus.sp !== 3'd0) begin miscompares++; $display("[TB] FAIL unf_sp got %0d exp 0", bus.sp); end
        vectors++; if (bus.stack_overflow !== 1'b1) begin miscompares++; $display("[TB] FAIL ovf_sticky got %b exp 1", bus.stack_overflow); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        applyStimulus(10'h012, 10'h000, 1'b0, 1'b0);
        vectors++; if ({bus.stack_overflow, bus.stack_underflow} !== 2'b00) begin miscompares++; $display("[TB] FAIL flags_clr got %b exp 00", {bus.stack_overflow, bus.stack_underflow}); end
        tick();
    endtask

    task automatic test_stall();
        applyStimulus(10'h3E0, 10'h050, 1'b0, 1'b0);
        tick();
        for (int i = 0; i < 2; i++) begin
            applyStimulus(10'h0C0, 10'h051, 1'b0, 1'b1);
            vectors++; if (bus.fetch_control !== 2'b11) begin miscompares++; $display("[TB] FAIL stall_fc[%0d] got %b exp 11", i, bus.fetch_control); end
            vectors++; if (bus.jump_addr !== 8'hC0) begin miscompares++; $display("[TB] FAIL stall_addr[%0d] got %h exp C0", i, bus.jump_addr); end
            vectors++; if (bus.sp !== 3'd0) begin miscompares++; $display("[TB] FAIL stall_sp[%0d] got %0d exp 0", i, bus.sp); end
            tick();
        end
        applyStimulus(10'h0C0, 10'h051, 1'b0, 1'b0);
        vectors++; if (bus.fetch_control !== 2'b01) begin miscompares++; $display("[TB] FAIL unstall_fc got %b exp 01", bus.fetch_control); end
        tick();
        applyStimulus(10'h012, 10'h0C0, 1'b0, 1'b0);
        vectors++; if (bus.sp !== 3'd1) begin miscompares++; $display("[TB] FAIL unstall_sp got %0d exp 1", bus.sp); end
        vectors++; if (bus.ra_addr !== 10'h052) begin miscompares++; $display("[TB] FAIL unstall_ra got %h exp 052", bus.ra_addr); end
        tick();
    endtask

    task automatic test_wrap();
        applyStimulus(10'h3E0, 10'h3FE, 1'b0, 1'b0);
        tick();
        applyStimulus(10'h010, 10'h3FF, 1'b0, 1'b0);
        vectors++; if (bus.fetch_control !== 2'b01) begin miscompares++; $display("[TB] FAIL wrap_fc got %b exp 01", bus.fetch_control); end
        tick();
        applyStimulus(10'h012, 10'h010, 1'b0, 1'b0);
        vectors++; if (bus.sp !== 3'd2) begin miscompares++; $display("[TB] FAIL wrap_sp got %0d exp 2", bus.sp); end
        vectors++; if (bus.ra_addr !== 10'h000) begin miscompares++; $display("[TB] FAIL wrap_ra got %h exp 000", bus.ra_addr); end
        tick();
    endtask

    task automatic test_reset_mid();
        applyStimulus(10'h3E0, 10'h060, 1'b0, 1'b0);
        tick();
        reset = 1'b1;
        applyStimulus(10'h070, 10'h061, 1'b0, 1'b0);
        vectors++; if (bus.fetch_control !== 2'b00) begin miscompares++; $display("[TB] FAIL midrst_fc got %b exp 00", bus.fetch_control); end
        vectors++; if (bus.jump_addr !== 8'h00) begin miscompares++; $display("[TB] FAIL midrst_addr got %h exp 00", bus.jump_addr); end
        tick();
        reset = 1'b0;
        applyStimulus(10'h012, 10'h070, 1'b0, 1'b0);
        vectors++; if (bus.fetch_control !== 2'b00) begin miscompares++; $display("[TB] FAIL postrst_fc got %b exp 00", bus.fetch_control); end
        vectors++; if (bus.jump_addr !== 8'h00) begin miscompares++; $display("[TB] FAIL postrst_addr got %h exp 00", bus.jump_addr); end
        vectors++; if (bus.sp !== 3'd0) begin miscompares++; $display("[TB] FAIL postrst_sp got %0d exp 0", bus.sp); end
        tick();
        applyStimulus(10'h012, 10'h071, 1'b0, 1'b0);
        vectors++; if (bus.sp !== 3'd0) begin miscompares++; $display("[TB] FAIL postrst_nopush got %0d exp 0", bus.sp); end
        tick();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        test_reset();
        test_jmp();
        test_jz();
        test_call_ret();
        test_stack_bounds();
        test_stall();
        test_wrap();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
